arith_op_scheduler: RTL and testbench
=====================================

// Module: arith_op_scheduler
// PURPOSE
//  Shares one add/subtract datapath (Adder, Subtractor, result mux) between NUM_REQ requesters.
//  Arbitrates round-robin, captures the winner's operands and op, and drives the shared
//  operands and the mux select for ALU_LAT cycles. Returns the result with a valid/ready
//  handshake. Sits beside the datapath in top and replaces direct tie-off of a/c/s.
// PARAMETERS
//  NUM_REQ   2  number of requesters (>=2)
//  WIDTH     8  operand/result width in bits
//  ALU_LAT   1  cycles from operands stable to alu_result valid (>=1)
// PORTS
//  clk         in   1              single clock, all state on rising edge
//  reset       in   1              synchronous, active-high
//  req         in   NUM_REQ        per-requester request; held with operands until gnt
//  req_a       in   NUM_REQ*WIDTH  operand A per requester, slice i = [i*WIDTH +: WIDTH]
//  req_b       in   NUM_REQ*WIDTH  operand B per requester
//  req_op      in   NUM_REQ        0 = add (A+B), 1 = subtract (A-B)
//  gnt         out  NUM_REQ        one-hot grant; operands sampled on the gnt cycle
//  alu_a       out  WIDTH          shared datapath operand A
//  alu_b       out  WIDTH          shared datapath operand B
//  alu_sel     out  1              result mux select: 0 = adder, 1 = subtractor
//  alu_result  in   WIDTH          selected datapath result
//  rsp_valid   out  1              response valid
//  rsp_ready   in   1              response accepted when rsp_valid & rsp_ready
//  rsp_id      out  clog2(NUM_REQ) index of the requester that owns rsp_data
//  rsp_data    out  WIDTH          captured result
//  busy        out  1              high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, cnt=0; gnt, alu_a, alu_b, alu_sel, rsp_valid, rsp_id,
//   rsp_data and busy are all 0. A reset in any state discards the in-flight op with no rsp.
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: if req!=0, gnt is combinational one-hot for the first set bit searching from rr_ptr
//   upward with wrap. On that edge: capture A, B, op and id into registers, set cnt=0,
//   set rr_ptr=(id+1)%NUM_REQ, go to EXEC. No other state asserts gnt.
//  EXEC: alu_a, alu_b and alu_sel come from the registers and stay stable for the whole state.
//   cnt increments every cycle. On the cycle where cnt==ALU_LAT-1, capture alu_result into
//   rsp_data and go to RESP.
//  RESP: rsp_valid=1, with rsp_data and rsp_id held until rsp_valid&rsp_ready, then go to IDLE.
//   alu_* hold their last values. No grant is issued until IDLE is re-entered, so there is
//   no back-to-back overlap.
//  Latency: gnt at cycle T -> rsp_valid first high at T+1+ALU_LAT.
//   Minimum issue interval is ALU_LAT+2 cycles.
//  Arithmetic: the block does not compute. Results are modulo 2^WIDTH with no flag.
//   The bench model wraps: 0xFF+0x02=0x01, 0x05-0x07=0xFE.
//  Boundaries:
//   - A req that drops outside IDLE is ignored.
//   - A req that stays high is re-arbitrated only in the next IDLE.
//   - All requesters active: strict rotation, so no starvation.
//   - rsp_ready high while rsp_valid is low has no effect.
// STRUCTURE
//  arith_sched_pkg holds OP_ADD=1'b0, OP_SUB=1'b1, and the state enum {IDLE, EXEC, RESP}.
//  Sub-module rr_arbiter #(N) is a purely combinational one-hot picker:
//   (req, ptr) -> gnt_onehot, gnt_idx.
//  FSM, counter, operand registers and response registers live in this module.
// TESTING (bench models the datapath: alu_result = sel ? a-b : a+b, delayed ALU_LAT cycles)
//  1 After reset, req[0] add 0x12,0x34 with rsp_ready=1 -> gnt=01 at T; alu_sel=0 at T+1;
//    rsp_valid at T+2; rsp_data=0x46; rsp_id=0.
//  2 req[1] sub 0x05,0x07 -> alu_sel=1 throughout EXEC; rsp_data=0xFE; rsp_id=1.
//  3 req=11 held continuously, rsp_ready=1 -> grants alternate 01,10,01,10;
//    gnt edges are 3 cycles apart.
//  4 rsp_ready low for 3 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable; busy=1;
//    gnt=0; IDLE one cycle after ready rises.
//  5 reset pulsed during EXEC -> next cycle every output is 0 and no rsp_valid.
//    A following req[1] alone is granted (rr_ptr=0 skips the empty slot).
//  6 ALU_LAT=3 build, 0xFF+0x02 -> alu_* stable 3 cycles; rsp_valid at T+4; rsp_data=0x01.

Source files
------------

// File: rtl/arith_sched_pkg.sv
// Shared op encodings and FSM state type for the add/subtract operation scheduler.
package arith_sched_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/arith_op_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping around.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt_onehot,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic found;
  int   k;

  // NOTE: every output gets a default before the search loop, so no path leaves them unassigned (no latch).
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    k          = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!found && req[k]) begin
        found         = 1'b1;
        gnt_onehot[k] = 1'b1;
        gnt_idx       = IW'(k);
      end
    end
  end

endmodule

// File: rtl/arith_op_scheduler.sv
// Time-shares one add/subtract datapath between NUM_REQ requesters with round-robin
// arbitration and a valid/ready response port.
module arith_op_scheduler
  import arith_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic [NUM_REQ-1:0]         req_op,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic                       alu_sel,
  input  logic [WIDTH-1:0]           alu_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(ALU_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LAT - 1);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   cur_id;
  logic [CW-1:0]    cnt;
  logic [NUM_REQ-1:0] arb_onehot;
  logic [IDW-1:0]   arb_idx;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req        (req),
    .ptr        (rr_ptr),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx)
  );

  // Grant only while idle; a reset cycle never grants since that capture would be discarded.
  assign gnt       = (state == IDLE && !reset) ? arb_onehot : '0;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cur_id   <= '0;
      cnt      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= OP_ADD;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            alu_a   <= req_a[int'(arb_idx)*WIDTH +: WIDTH];
            alu_b   <= req_b[int'(arb_idx)*WIDTH +: WIDTH];
            alu_sel <= req_op[arb_idx];
            cur_id  <= arb_idx;
            cnt     <= '0;
            if (int'(arb_idx) == NUM_REQ - 1) rr_ptr <= '0;
            else                              rr_ptr <= arb_idx + 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            rsp_data <= alu_result;
            rsp_id   <= cur_id;
            state    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_op_scheduler.sv
// Directed bench for arith_op_scheduler with a transaction-level model checked every cycle.
module tb_arith_op_scheduler;

  localparam int NR  = 2;
  localparam int W   = 8;
  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [NR-1:0]   req, req_op, gnt;
  logic [NR*W-1:0] req_a, req_b;
  logic [W-1:0]    alu_a, alu_b, alu_result, rsp_data;
  logic            alu_sel, rsp_valid, rsp_ready, busy;
  logic [0:0]      rsp_id;

  logic [NR-1:0]   r3_req, r3_op, gnt3;
  logic [NR*W-1:0] r3_a, r3_b;
  logic [W-1:0]    alu3_a, alu3_b, alu3_result, rsp3_data, alu3_p0, alu3_p1, alu3_p2;
  logic            alu3_sel, rsp3_valid, r3_ready, busy3;
  logic [0:0]      rsp3_id;

  arith_op_scheduler #(.NUM_REQ(NR), .WIDTH(W), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .gnt(gnt), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
  );

  arith_op_scheduler #(.NUM_REQ(NR), .WIDTH(W), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .req(r3_req), .req_a(r3_a), .req_b(r3_b), .req_op(r3_op),
    .gnt(gnt3), .alu_a(alu3_a), .alu_b(alu3_b), .alu_sel(alu3_sel), .alu_result(alu3_result),
    .rsp_valid(rsp3_valid), .rsp_ready(r3_ready), .rsp_id(rsp3_id), .rsp_data(rsp3_data),
    .busy(busy3)
  );

  // Datapath models: single-cycle combinational, and a 3-cycle version with two pipeline stages.
  assign alu_result = alu_sel ? alu_a - alu_b : alu_a + alu_b;
  assign alu3_p0    = alu3_sel ? alu3_a - alu3_b : alu3_a + alu3_b;
  always @(posedge clk) begin
    alu3_p1 <= alu3_p0;
    alu3_p2 <= alu3_p1;
  end
  assign alu3_result = alu3_p2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Transaction model: one job at a time, age counted in cycles since its grant.
  logic         chk_en = 1'b0;
  bit           m_active = 1'b0;
  int           m_age = 0, m_ptr = 0, m_id = 0, m_rsp_id = 0;
  logic [W-1:0] m_alu_a = '0, m_alu_b = '0, m_res = '0, m_rsp_data = '0;
  logic         m_sel = 1'b0;

  always @(negedge clk) begin
    int pick;
    logic [NR-1:0] eg;
    if (chk_en) begin
      pick = -1;
      eg   = '0;
      if (!reset && !m_active)
        for (int i = 0; i < NR; i++)
          if (pick < 0 && req[(m_ptr + i) % NR]) pick = (m_ptr + i) % NR;
      if (pick >= 0) eg[pick] = 1'b1;

      check("m_gnt",       32'(gnt),       32'(eg));
      check("m_busy",      32'(busy),      32'(m_active));
      check("m_rsp_valid", 32'(rsp_valid), 32'(m_active && m_age > LAT));
      check("m_alu_a",     32'(alu_a),     32'(m_alu_a));
      check("m_alu_b",     32'(alu_b),     32'(m_alu_b));
      check("m_alu_sel",   32'(alu_sel),   32'(m_sel));
      check("m_rsp_data",  32'(rsp_data),  32'(m_rsp_data));
      check("m_rsp_id",    32'(rsp_id),    32'(m_rsp_id));

      if (reset) begin
        m_active = 1'b0; m_age = 0; m_ptr = 0; m_id = 0; m_rsp_id = 0;
        m_alu_a = '0; m_alu_b = '0; m_sel = 1'b0; m_rsp_data = '0;
      end else if (!m_active) begin
        if (pick >= 0) begin
          m_active = 1'b1;
          m_age    = 1;
          m_id     = pick;
          m_alu_a  = req_a[pick*W +: W];
          m_alu_b  = req_b[pick*W +: W];
          m_sel    = req_op[pick];
          m_res    = m_sel ? m_alu_a - m_alu_b : m_alu_a + m_alu_b;
          m_ptr    = (pick + 1) % NR;
        end
      end else if (m_age > LAT) begin
        if (rsp_ready) m_active = 1'b0;
      end else begin
        if (m_age == LAT) begin
          m_rsp_data = m_res;
          m_rsp_id   = m_id;
        end
        m_age++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      at_neg();
      n++;
    end
    check("idle_wait", 32'(busy), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_cyc, n;
    reset = 1'b1; req = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
    r3_req = '0; r3_a = '0; r3_b = '0; r3_op = '0; r3_ready = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    step();
    at_neg();
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_valid", 32'(rsp_valid), 32'h0);
    step();
    reset = 1'b0;

    // 1: requester 0 adds 0x12 + 0x34
    req = 2'b01; req_a[7:0] = 8'h12; req_b[7:0] = 8'h34; req_op = 2'b00;
    at_neg();
    check("t1_gnt", 32'(gnt), 32'h1);
    step();
    req = '0;
    at_neg();
    check("t1_sel", 32'(alu_sel), 32'h0);
    check("t1_valid_exec", 32'(rsp_valid), 32'h0);
    at_neg();
    check("t1_valid", 32'(rsp_valid), 32'h1);
    check("t1_data", 32'(rsp_data), 32'h46);
    check("t1_id", 32'(rsp_id), 32'h0);

    // 2: requester 1 subtracts 0x05 - 0x07, wraps to 0xFE
    step();
    req = 2'b10; req_a[15:8] = 8'h05; req_b[15:8] = 8'h07; req_op = 2'b10;
    at_neg();
    check("t2_gnt", 32'(gnt), 32'h2);
    step();
    req = '0;
    at_neg();
    check("t2_sel", 32'(alu_sel), 32'h1);
    at_neg();
    check("t2_sel_resp", 32'(alu_sel), 32'h1);
    check("t2_data", 32'(rsp_data), 32'hFE);
    check("t2_id", 32'(rsp_id), 32'h1);

    // 3: both requesting continuously: strict alternation, 3 cycles apart
    step();
    req = 2'b11; req_a = {8'h10, 8'h20}; req_b = {8'h01, 8'h03}; req_op = 2'b10;
    last_cyc = 0;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      at_neg();
      while (gnt == '0 && n < 8) begin
        at_neg();
        n++;
      end
      check("t3_gnt", 32'(gnt), (g % 2 == 0) ? 32'h1 : 32'h2);
      if (g > 0) check("t3_spacing", 32'(cyc - last_cyc), 32'd3);
      last_cyc = cyc;
    end
    step();
    req = '0;
    wait_idle();

    // 4: response stalled 3 cycles while requester 1 waits
    step();
    req = 2'b01; req_a[7:0] = 8'h80; req_b[7:0] = 8'h80; req_op = 2'b00; rsp_ready = 1'b0;
    at_neg();
    check("t4_gnt", 32'(gnt), 32'h1);
    step();
    req = '0;
    at_neg();
    step();
    req = 2'b10; req_a[15:8] = 8'h05; req_b[15:8] = 8'h07; req_op = 2'b10;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      check("t4_valid", 32'(rsp_valid), 32'h1);
      check("t4_data", 32'(rsp_data), 32'h00);
      check("t4_id", 32'(rsp_id), 32'h0);
      check("t4_busy", 32'(busy), 32'h1);
      check("t4_nognt", 32'(gnt), 32'h0);
      if (k < 2) step();
    end
    step();
    rsp_ready = 1'b1;
    at_neg();
    check("t4_accept_valid", 32'(rsp_valid), 32'h1);
    step();
    at_neg();
    check("t4_idle", 32'(busy), 32'h0);
    check("t4_regnt", 32'(gnt), 32'h2);
    step();
    req = '0;
    wait_idle();

    // 5: reset during EXEC discards the op; pointer returns to 0
    step();
    req = 2'b01; req_a[7:0] = 8'h33; req_b[7:0] = 8'h11; req_op = 2'b01;
    at_neg();
    check("t5_gnt", 32'(gnt), 32'h1);
    step();
    req = '0; reset = 1'b1;
    at_neg();
    check("t5_busy_pre", 32'(busy), 32'h1);
    step();
    reset = 1'b0;
    at_neg();
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_valid", 32'(rsp_valid), 32'h0);
    check("t5_alu_a", 32'(alu_a), 32'h0);
    check("t5_data", 32'(rsp_data), 32'h0);
    step();
    req = 2'b10; req_a[15:8] = 8'hFF; req_b[15:8] = 8'h02; req_op = 2'b00;
    at_neg();
    check("t5_gnt1", 32'(gnt), 32'h2);
    step();
    req = '0;
    at_neg();
    at_neg();
    check("t5_data_wrap", 32'(rsp_data), 32'h01);
    check("t5_id", 32'(rsp_id), 32'h1);
    step();

    // 6: three-cycle datapath instance, 0xFF + 0x02
    r3_req = 2'b01; r3_a[7:0] = 8'hFF; r3_b[7:0] = 8'h02; r3_op = 2'b00;
    at_neg();
    check("t6_gnt", 32'(gnt3), 32'h1);
    step();
    r3_req = '0;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      check("t6_alu_a", 32'(alu3_a), 32'hFF);
      check("t6_alu_b", 32'(alu3_b), 32'h02);
      check("t6_sel", 32'(alu3_sel), 32'h0);
      check("t6_valid_exec", 32'(rsp3_valid), 32'h0);
      check("t6_busy", 32'(busy3), 32'h1);
    end
    at_neg();
    check("t6_valid", 32'(rsp3_valid), 32'h1);
    check("t6_data", 32'(rsp3_data), 32'h01);
    check("t6_id", 32'(rsp3_id), 32'h0);
    step();
    at_neg();
    check("t6_idle", 32'(busy3), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
